// File: rtl/pid_bus_master_pkg.sv
// Shared definitions for the PID local-bus master: command opcodes,
// FSM state encoding and the per-channel register offsets.
package pid_bus_master_pkg;

    // Command operations carried on cmd_op
    typedef enum logic [1:0] {
        OP_WRITE        = 2'd0,
        OP_READ         = 2'd1,
        OP_WRITE_VERIFY = 2'd2,
        OP_SWEEP_VERIFY = 2'd3
    } op_e;

    // Bus master FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RDWAIT = 3'd4,
        ST_SAMPLE = 3'd5,
        ST_NEXT   = 3'd6,
        ST_RESP   = 3'd7
    } state_e;

    // Register offsets inside one PID channel (address bits [1:0])
    localparam logic [1:0] REG_CFG = 2'd0;
    localparam logic [1:0] REG_EW  = 2'd1;
    localparam logic [1:0] REG_PW  = 2'd2;
    localparam logic [1:0] REG_MW  = 2'd3;

    // Compose a local-bus address from a channel number and register offset
    function automatic logic [7:0] bus_addr(input logic [5:0] ch, input logic [1:0] regsel);
        return {ch, regsel};
    endfunction

endpackage

// File: rtl/pid_bus_master_phy.sv
// Local-bus strobe generator. Given the master's FSM state it drives
// Address/DataIn/Read/Write and times the read-wait window.
module pid_bus_phy
    import pid_bus_master_pkg::*;
#(
    parameter int RD_WAIT = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  state_e       i_state,
    input  logic         i_rd_phase,
    input  logic [7:0]   i_addr,
    input  logic [31:0]  i_wdata,
    output logic [7:0]   o_addr,
    output logic [31:0]  o_wdata,
    output logic         o_read,
    output logic         o_write,
    output logic         o_rd_last
);

    // RDWAIT covers the first RD_WAIT-1 Read cycles; SAMPLE is the last one.
    localparam logic [2:0] WAIT_LAST = (RD_WAIT >= 2) ? 3'(RD_WAIT - 2) : 3'd0;

    logic [2:0] r_wcnt;
    logic       w_active;

    // Count cycles spent in RDWAIT; cleared whenever the FSM is elsewhere
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wcnt <= 3'd0;
        end else if (i_state == ST_RDWAIT) begin
            r_wcnt <= r_wcnt + 3'd1;
        end else begin
            r_wcnt <= 3'd0;
        end
    end

    // Drive bus outputs from the state; everything is zero outside a bus access
    always_comb begin
        w_active  = (i_state == ST_SETUP)  || (i_state == ST_STROBE) ||
                    (i_state == ST_HOLD)   || (i_state == ST_RDWAIT) ||
                    (i_state == ST_SAMPLE);
        o_addr    = w_active ? i_addr : 8'd0;
        o_wdata   = (w_active && !i_rd_phase) ? i_wdata : 32'd0;
        o_write   = (i_state == ST_STROBE);
        o_read    = (i_state == ST_RDWAIT) || (i_state == ST_SAMPLE);
        o_rd_last = (i_state == ST_RDWAIT) && (r_wcnt == WAIT_LAST);
    end

endmodule

// File: rtl/pid_bus_master.sv
// PID register bus master: accepts write/read/verify/sweep commands,
// sequences local-bus accesses through pid_bus_phy and reports one
// response per command, including the first verify mismatch of a sweep.
module pid_bus_master
    import pid_bus_master_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int RD_WAIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [7:0]   cmd_addr,
    input  logic [31:0]  cmd_wdata,
    output logic         rsp_valid,
    output logic [31:0]  rsp_data,
    output logic         rsp_err,
    output logic [5:0]   rsp_ch,
    output logic [7:0]   Address,
    output logic [31:0]  DataIn,
    input  logic [31:0]  DataOut,
    output logic         Read,
    output logic         Write
);

    localparam logic [5:0] LAST_CH = 6'(NCH - 1);

    state_e      r_state;
    state_e      w_next;
    logic        r_rst_s1;
    logic        r_rst_s2;
    op_e         r_op;
    logic [7:0]  r_addr;
    logic [31:0] r_wdata;
    logic [5:0]  r_ch;
    logic        r_rd_phase;
    logic        r_err;
    logic [31:0] r_rsp_data;
    logic [5:0]  r_rsp_ch;

    logic        w_accept;
    logic        w_sweep;
    logic        w_verify;
    logic        w_last_ch;
    logic        w_rd_last;
    logic        w_resp;
    logic [5:0]  w_cur_ch;
    logic [7:0]  w_bus_addr;

    // Two-flop synchroniser so reset release is seen cleanly by the FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_s1 <= 1'b0;
            r_rst_s2 <= 1'b0;
        end else begin
            r_rst_s1 <= 1'b1;
            r_rst_s2 <= r_rst_s1;
        end
    end

    // Decode the latched command and current channel
    always_comb begin
        w_sweep    = (r_op == OP_SWEEP_VERIFY);
        w_verify   = (r_op == OP_WRITE_VERIFY) || (r_op == OP_SWEEP_VERIFY);
        w_last_ch  = (r_ch == LAST_CH);
        w_cur_ch   = w_sweep ? r_ch : r_addr[7:2];
        w_bus_addr = bus_addr(w_cur_ch, r_addr[1:0]);
        w_accept   = (r_state == ST_IDLE) && cmd_valid && r_rst_s2;
        w_resp     = (r_state == ST_RESP);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: write leg, then read-back leg for verify ops, looping per channel for sweeps
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_SETUP;
            ST_SETUP: begin
                if (!r_rd_phase)       w_next = ST_STROBE;
                else if (RD_WAIT == 1) w_next = ST_SAMPLE;
                else                   w_next = ST_RDWAIT;
            end
            ST_STROBE: w_next = ST_HOLD;
            ST_HOLD:   w_next = (r_op == OP_WRITE) ? ST_RESP : ST_SETUP;
            ST_RDWAIT: if (w_rd_last) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = w_sweep ? ST_NEXT : ST_RESP;
            ST_NEXT:   w_next = w_last_ch ? ST_RESP : ST_SETUP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake and response, held at zero outside the response cycle
    always_comb begin
        cmd_ready = (r_state == ST_IDLE) && (r_rst_s2 || !rst);
        rsp_valid = w_resp;
        rsp_data  = w_resp ? r_rsp_data : 32'd0;
        rsp_err   = w_resp && r_err;
        rsp_ch    = w_resp ? r_rsp_ch : 6'd0;
    end

    // Command latch, sweep channel counter and first-mismatch capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op       <= OP_WRITE;
            r_addr     <= 8'd0;
            r_wdata    <= 32'd0;
            r_ch       <= 6'd0;
            r_rd_phase <= 1'b0;
            r_err      <= 1'b0;
            r_rsp_data <= 32'd0;
            r_rsp_ch   <= 6'd0;
        end else begin
            if (w_accept) begin
                r_op       <= op_e'(cmd_op);
                r_addr     <= cmd_addr;
                r_wdata    <= cmd_wdata;
                r_ch       <= 6'd0;
                r_rd_phase <= (op_e'(cmd_op) == OP_READ);
                r_err      <= 1'b0;
                r_rsp_data <= cmd_wdata;
                r_rsp_ch   <= (op_e'(cmd_op) == OP_SWEEP_VERIFY) ? 6'd0 : cmd_addr[7:2];
            end
            if (r_state == ST_HOLD && r_op != OP_WRITE) begin
                r_rd_phase <= 1'b1;
            end
            // Once a mismatch is recorded, later readbacks leave the report untouched
            if (r_state == ST_SAMPLE && !r_err) begin
                r_rsp_data <= DataOut;
                r_rsp_ch   <= w_cur_ch;
                if (w_verify && (DataOut != r_wdata)) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == ST_NEXT && !w_last_ch) begin
                r_ch       <= r_ch + 6'd1;
                r_rd_phase <= 1'b0;
            end
        end
    end

    pid_bus_phy #(
        .RD_WAIT (RD_WAIT)
    ) u_phy (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_state    (r_state),
        .i_rd_phase (r_rd_phase),
        .i_addr     (w_bus_addr),
        .i_wdata    (r_wdata),
        .o_addr     (Address),
        .o_wdata    (DataIn),
        .o_read     (Read),
        .o_write    (Write),
        .o_rd_last  (w_rd_last)
    );

endmodule

// File: doc/pid_bus_master.md
PID_BUS_MASTER -- requirements
Module: pid_bus_master

Interface
REQ-001 Parameter NCH, default 8, number of PID channels addressed by sweep commands (1..64).
REQ-002 Parameter RD_WAIT, default 2, cycles Read is held before read data is sampled (1..7).
REQ-003 Port clk, input, 1, single 50 MHz clock; all logic on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous and active-low.
REQ-005 Port cmd_valid, input, 1, command offered.
REQ-006 Port cmd_ready, output, 1, master idle and accepting a command.
REQ-007 Port cmd_op, input, 2, operation: 0=WRITE, 1=READ, 2=WRITE_VERIFY, 3=SWEEP_VERIFY.
REQ-008 Port cmd_addr, input, 8, bus address; channel in [7:2], register in [1:0].
REQ-009 Port cmd_wdata, input, 32, write data.
REQ-010 Port rsp_valid, output, 1, one-cycle response strobe.
REQ-011 Port rsp_data, output, 32, read data, or the first mismatching readback.
REQ-012 Port rsp_err, output, 1, verify mismatch flag, qualified by rsp_valid.
REQ-013 Port rsp_ch, output, 6, channel of the first mismatch, or of the last access.
REQ-014 Port Address, output, 8, local-bus address.
REQ-015 Port DataIn, output, 32, local-bus write data to the register slaves.
REQ-016 Port DataOut, input, 32, wired-OR read data from the register slaves.
REQ-017 Ports Read and Write, output, 1 each, local-bus strobes.

Function
REQ-018 Accept a command when cmd_valid and cmd_ready are both high; latch op, address and data; deassert cmd_ready the next cycle until the response cycle completes.
REQ-019 FSM states: IDLE, SETUP, STROBE, HOLD, RDWAIT, SAMPLE, NEXT, RESP.
REQ-020 A write runs IDLE->SETUP->STROBE->HOLD: Address and DataIn are stable in all three cycles, and Write is high in STROBE only, for exactly one cycle.
REQ-021 A read runs SETUP->RDWAIT, with Read high for RD_WAIT cycles; DataOut is captured on the last Read-high cycle (SAMPLE); Read drops the following cycle.
REQ-022 WRITE goes HOLD->RESP with rsp_err=0 and rsp_data=written data; latency from accept to rsp_valid is 4 cycles.
REQ-023 READ returns the captured DataOut with rsp_err=0; latency from accept to rsp_valid is RD_WAIT+2 cycles.
REQ-024 WRITE_VERIFY performs the write, then a read of the same address; rsp_err=1 if readback differs from the written data.
REQ-025 SWEEP_VERIFY applies WRITE_VERIFY to addresses {ch,cmd_addr[1:0]} for ch=0..NCH-1 in ascending order; cmd_addr[7:2] is ignored.
REQ-026 In a sweep, the channel counter increments in NEXT and ends after NCH-1; there is no wrap.
REQ-027 In a sweep, the first mismatch is recorded in rsp_ch and rsp_data; later mismatches do not overwrite it, and the sweep completes.
REQ-028 Only one bus strobe is active in any cycle; Read and Write are never high together.
REQ-029 Outside SETUP, STROBE, HOLD, RDWAIT and SAMPLE, Address, DataIn, Read and Write are driven to 0.
REQ-030 rsp_valid is high for exactly one cycle in RESP; cmd_ready rises the cycle after.
REQ-031 A cmd_valid asserted during RESP is not accepted until cmd_ready is high.

Reset
REQ-032 While rst is low, the FSM is in IDLE, all outputs are 0 except cmd_ready, and the channel counter and mismatch flag are 0.
REQ-033 cmd_ready is 1 during reset.
REQ-034 Reset asserted mid-transaction aborts the transaction: strobes drop immediately and no response is issued.
REQ-035 Deassertion of rst is synchronised by two flops; the first command can be accepted 2 cycles after rst rises.

Structure
REQ-036 A shared package holds the cmd_op encodings, the FSM state encoding, and the register offsets CFG=0, EW=1, PW=2, MW=3.
REQ-037 The sub-module pid_bus_phy implements the SETUP/STROBE/HOLD/RDWAIT strobe timing; the top holds command, sweep and compare logic.

Verification
REQ-038 WRITE addr 0x05, data 0xDEADBEEF -> Write high one cycle with Address=0x05 and DataIn=0xDEADBEEF; rsp_valid 4 cycles after accept with rsp_err=0.
REQ-039 READ addr 0x02 with a slave model returning 0x0000F000 (PW reset value) -> rsp_data=0x0000F000, Read high exactly 2 cycles.
REQ-040 WRITE_VERIFY addr 0x07, data 0x0F000000, slave stores the value -> rsp_err=0; with the slave forcing bit 3 stuck-at-1 -> rsp_err=1, rsp_data=0x0F000008.
REQ-041 SWEEP_VERIFY reg EW, data 0xFFFF0000, NCH=8, with a bad channel 5 -> 8 writes at 0x01,0x05,...,0x1D; rsp_err=1, rsp_ch=5.
REQ-042 rst pulled low during the STROBE of the third sweep channel -> Write drops asynchronously, no rsp_valid, cmd_ready=1; the next command runs normally.
REQ-043 Back-to-back commands with cmd_valid held high -> second accepted the cycle after RESP; Read and Write never overlap.
